// File: rtl/load_store_unit_if.sv
// Execute-stage request and writeback handshake for the load/store unit.
// The execute side is the master; the load/store unit is the slave.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_is_load;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_store_data;
    logic [4:0]  req_rd;
    logic        req_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_value;
    logic        access_err;

    modport master (
        output req_valid, req_is_load, req_is_store, req_funct3,
               req_addr, req_store_data, req_rd,
        input  req_ready, wb_valid, wb_rd, wb_value, access_err
    );

    modport slave (
        input  req_valid, req_is_load, req_is_store, req_funct3,
               req_addr, req_store_data, req_rd,
        output req_ready, wb_valid, wb_rd, wb_value, access_err
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I memory stage: stores take one cycle, loads READ_LATENCY cycles plus one for writeback.
// req_ready is high only in IDLE, so the execute stage stalls while an access is in flight.
module load_store_unit #(
    parameter int unsigned READ_LATENCY = 1  // legal range 1..4
) (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave lsu,
    output logic [31:0]      dmem_addr,
    output logic             dmem_wen,
    output logic [3:0]       dmem_be,
    inout  wire  [31:0]      dmem_data
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(READ_LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    logic        ready;

    logic [2:0]  lat_cnt;
    logic [1:0]  lane_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_value_q;

    logic [1:0]  req_size;
    logic        req_active;
    logic        req_misaligned;
    logic        req_illegal;
    logic        req_err;
    logic        accept_ok;
    logic        load_done;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [31:0] rd_shifted;
    logic [31:0] load_ext;

    assign req_size = lsu.req_funct3[1:0];

    always_comb begin
        req_misaligned = ((req_size == 2'd1) && lsu.req_addr[0]) ||
                         ((req_size == 2'd2) && (lsu.req_addr[1:0] != 2'b00));
        req_illegal    = (lsu.req_is_load && lsu.req_is_store) ||
                         (lsu.req_is_load && ((lsu.req_funct3 == 3'd3) ||
                                              (lsu.req_funct3 == 3'd6) ||
                                              (lsu.req_funct3 == 3'd7))) ||
                         (lsu.req_is_store && (lsu.req_funct3 >= 3'd3));
        req_active     = lsu.req_valid && (state == IDLE) &&
                         (lsu.req_is_load || lsu.req_is_store);
        req_err        = req_active && (req_misaligned || req_illegal);
        accept_ok      = req_active && !(req_misaligned || req_illegal);
    end

    // Lane mask and lane-replicated store data, shared by loads and stores.
    always_comb begin
        req_be    = 4'b1111;
        req_wdata = lsu.req_store_data;
        case (req_size)
            2'd0: begin
                req_be    = 4'b0001 << lsu.req_addr[1:0];
                req_wdata = {4{lsu.req_store_data[7:0]}};
            end
            2'd1: begin
                req_be    = 4'b0011 << {lsu.req_addr[1], 1'b0};
                req_wdata = {2{lsu.req_store_data[15:0]}};
            end
            default: begin
                req_be    = 4'b1111;
                req_wdata = lsu.req_store_data;
            end
        endcase
    end

    assign load_done = (state == LOAD) && (lat_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        dmem_wen  = 1'b0;
        dmem_be   = 4'b0000;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (accept_ok) begin
                    state_nxt = lsu.req_is_load ? LOAD : STORE;
                end
            end
            STORE: begin
                dmem_wen  = 1'b1;
                dmem_be   = be_q;
                state_nxt = IDLE;
            end
            LOAD: begin
                dmem_be = be_q;
                if (load_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus is released the instant state leaves STORE, including on async reset.
    assign dmem_data = dmem_wen ? wdata_q : 32'bz;

    always_comb begin
        rd_shifted = dmem_data >> {lane_q, 3'b000};
        case (funct3_q)
            3'd0:    load_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'd1:    load_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'd4:    load_ext = {24'd0, rd_shifted[7:0]};
            3'd5:    load_ext = {16'd0, rd_shifted[15:0]};
            default: load_ext = rd_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt    <= 3'd0;
            lane_q     <= 2'd0;
            funct3_q   <= 3'd0;
            rd_q       <= 5'd0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
            dmem_addr  <= 32'd0;
            err_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_value_q <= 32'd0;
        end else begin
            err_q      <= req_err;
            wb_valid_q <= 1'b0;
            if (accept_ok) begin
                lat_cnt   <= 3'd0;
                lane_q    <= lsu.req_addr[1:0];
                funct3_q  <= lsu.req_funct3;
                rd_q      <= lsu.req_rd;
                be_q      <= req_be;
                wdata_q   <= req_wdata;
                dmem_addr <= {lsu.req_addr[31:2], 2'b00};
            end else if ((state == LOAD) && !load_done) begin
                lat_cnt <= lat_cnt + 3'd1;
            end
            if (load_done) begin
                wb_valid_q <= 1'b1;
                wb_rd_q    <= rd_q;
                wb_value_q <= load_ext;
            end
        end
    end

    assign lsu.req_ready  = ready;
    assign lsu.access_err = err_q;
    assign lsu.wb_valid   = wb_valid_q;
    assign lsu.wb_rd      = wb_rd_q;
    assign lsu.wb_value   = wb_value_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with one instance at READ_LATENCY=1 and one at 3.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        use3 = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_is_load = 1'b0;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_store_data = 32'd0;
    logic [4:0]  req_rd = 5'd0;
    logic [31:0] mem_rdata = 32'h1234_5678;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit_if if1();
    load_store_unit_if if3();

    logic [31:0] addr1, addr3;
    logic        wen1, wen3;
    logic [3:0]  be1, be3;
    wire  [31:0] bus1, bus3;

    // Memory model drives read data whenever the unit is not writing.
    assign bus1 = wen1 ? 32'bz : mem_rdata;
    assign bus3 = wen3 ? 32'bz : mem_rdata;

    assign if1.req_valid      = req_valid && !use3;
    assign if3.req_valid      = req_valid && use3;
    assign if1.req_is_load    = req_is_load;
    assign if3.req_is_load    = req_is_load;
    assign if1.req_is_store   = req_is_store;
    assign if3.req_is_store   = req_is_store;
    assign if1.req_funct3     = req_funct3;
    assign if3.req_funct3     = req_funct3;
    assign if1.req_addr       = req_addr;
    assign if3.req_addr       = req_addr;
    assign if1.req_store_data = req_store_data;
    assign if3.req_store_data = req_store_data;
    assign if1.req_rd         = req_rd;
    assign if3.req_rd         = req_rd;

    load_store_unit #(.READ_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .lsu(if1),
        .dmem_addr(addr1), .dmem_wen(wen1), .dmem_be(be1), .dmem_data(bus1)
    );
    load_store_unit #(.READ_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .lsu(if3),
        .dmem_addr(addr3), .dmem_wen(wen3), .dmem_be(be3), .dmem_data(bus3)
    );

    wire        o_ready = use3 ? if3.req_ready  : if1.req_ready;
    wire        o_err   = use3 ? if3.access_err : if1.access_err;
    wire        o_wbv   = use3 ? if3.wb_valid   : if1.wb_valid;
    wire [4:0]  o_wbrd  = use3 ? if3.wb_rd      : if1.wb_rd;
    wire [31:0] o_wbval = use3 ? if3.wb_value   : if1.wb_value;
    wire [31:0] o_addr  = use3 ? addr3 : addr1;
    wire        o_wen   = use3 ? wen3  : wen1;
    wire [3:0]  o_be    = use3 ? be3   : be1;
    wire [31:0] o_bus   = use3 ? bus3  : bus1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Presents one request for a single cycle; returns at the midpoint of cycle k+1.
    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
        @(negedge clk);
        req_is_load    = ld;
        req_is_store   = st;
        req_funct3     = f3;
        req_addr       = a;
        req_store_data = d;
        req_rd         = rd;
        req_valid      = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic load_rl1(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] mem, input logic [4:0] rd,
                            input logic [31:0] exp_val, input logic [3:0] exp_be);
        mem_rdata = mem;
        issue(1'b1, 1'b0, f3, a, 32'd0, rd);
        chk({tag, "_busy"}, {31'd0, o_ready}, 32'd0);
        chk({tag, "_be"}, {28'd0, o_be}, {28'd0, exp_be});
        chk({tag, "_nowen"}, {31'd0, o_wen}, 32'd0);
        chk({tag, "_early"}, {31'd0, o_wbv}, 32'd0);
        @(negedge clk);
        chk({tag, "_wbv"}, {31'd0, o_wbv}, 32'd1);
        chk({tag, "_val"}, o_wbval, exp_val);
        chk({tag, "_rd"}, {27'd0, o_wbrd}, {27'd0, rd});
        chk({tag, "_rdy"}, {31'd0, o_ready}, 32'd1);
        @(negedge clk);
        chk({tag, "_wbv_end"}, {31'd0, o_wbv}, 32'd0);
    endtask

    task automatic load_rl3(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] mem, input logic [4:0] rd,
                            input logic [31:0] exp_val);
        mem_rdata = mem;
        issue(1'b1, 1'b0, f3, a, 32'd0, rd);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_busy"}, {31'd0, o_ready}, 32'd0);
            chk({tag, "_early"}, {31'd0, o_wbv}, 32'd0);
            chk({tag, "_be"}, {28'd0, o_be}, 32'hC);
            @(negedge clk);
        end
        chk({tag, "_wbv"}, {31'd0, o_wbv}, 32'd1);
        chk({tag, "_val"}, o_wbval, exp_val);
        chk({tag, "_rdy"}, {31'd0, o_ready}, 32'd1);
        @(negedge clk);
        chk({tag, "_wbv_end"}, {31'd0, o_wbv}, 32'd0);
    endtask

    task automatic err_req(input string tag, input logic ld, input logic st,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp_addr);
        issue(ld, st, f3, a, 32'hFFFF_FFFF, 5'd9);
        chk({tag, "_err"}, {31'd0, o_err}, 32'd1);
        chk({tag, "_be"}, {28'd0, o_be}, 32'd0);
        chk({tag, "_wen"}, {31'd0, o_wen}, 32'd0);
        chk({tag, "_rdy"}, {31'd0, o_ready}, 32'd1);
        chk({tag, "_addr"}, o_addr, exp_addr);
        @(negedge clk);
        chk({tag, "_err_end"}, {31'd0, o_err}, 32'd0);
        chk({tag, "_nowb"}, {31'd0, o_wbv}, 32'd0);
        chk({tag, "_nowb2"}, {31'd0, o_wbv}, 32'd0);
    endtask

    initial begin
        int pulses;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_wen", {31'd0, o_wen}, 32'd0);
        chk("rst_be", {28'd0, o_be}, 32'd0);
        chk("rst_addr", o_addr, 32'd0);
        chk("rst_wbv", {31'd0, o_wbv}, 32'd0);
        chk("rst_wbrd", {27'd0, o_wbrd}, 32'd0);
        chk("rst_wbval", o_wbval, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        use3 = 1'b1;
        #1;
        chk("rst3_ready", {31'd0, o_ready}, 32'd1);
        chk("rst3_be", {28'd0, o_be}, 32'd0);
        use3 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // SW
        mem_rdata = 32'h1234_5678;
        issue(1'b0, 1'b1, 3'd2, 32'h0000_0104, 32'hDEAD_BEEF, 5'd0);
        chk("sw_wen", {31'd0, o_wen}, 32'd1);
        chk("sw_addr", o_addr, 32'h0000_0104);
        chk("sw_be", {28'd0, o_be}, 32'hF);
        chk("sw_bus", o_bus, 32'hDEAD_BEEF);
        chk("sw_busy", {31'd0, o_ready}, 32'd0);
        @(negedge clk);
        chk("sw_wen_end", {31'd0, o_wen}, 32'd0);
        chk("sw_bus_rel", o_bus, 32'h1234_5678);
        chk("sw_rdy", {31'd0, o_ready}, 32'd1);
        chk("sw_be_end", {28'd0, o_be}, 32'd0);
        chk("sw_addr_hold", o_addr, 32'h0000_0104);

        // SB
        issue(1'b0, 1'b1, 3'd0, 32'h0000_0103, 32'h0000_00F0, 5'd0);
        chk("sb_wen", {31'd0, o_wen}, 32'd1);
        chk("sb_addr", o_addr, 32'h0000_0100);
        chk("sb_be", {28'd0, o_be}, 32'h8);
        chk("sb_bus", o_bus, 32'hF0F0_F0F0);

        // SH upper half
        issue(1'b0, 1'b1, 3'd1, 32'h0000_0106, 32'h1111_ABCD, 5'd0);
        chk("sh_be", {28'd0, o_be}, 32'hC);
        chk("sh_bus", o_bus, 32'hABCD_ABCD);
        @(negedge clk);

        // Loads at READ_LATENCY=1
        load_rl1("lb", 3'd0, 32'h0000_0103, 32'hF000_0000, 5'd7, 32'hFFFF_FFF0, 4'h8);
        load_rl1("lbu", 3'd4, 32'h0000_0103, 32'hF000_0000, 5'd0, 32'h0000_00F0, 4'h8);
        load_rl1("lb1", 3'd0, 32'h0000_0101, 32'h0000_7F00, 5'd2, 32'h0000_007F, 4'h2);
        load_rl1("lh0", 3'd1, 32'h0000_0100, 32'h0000_9234, 5'd11, 32'hFFFF_9234, 4'h3);
        load_rl1("lw", 3'd2, 32'h0000_0108, 32'h89AB_CDEF, 5'd31, 32'h89AB_CDEF, 4'hF);

        // Loads at READ_LATENCY=3
        use3 = 1'b1;
        load_rl3("lh3", 3'd1, 32'h0000_0102, 32'h8001_0000, 5'd5, 32'hFFFF_8001);
        load_rl3("lhu3", 3'd5, 32'h0000_0102, 32'h8001_0000, 5'd6, 32'h0000_8001);
        use3 = 1'b0;

        // Rejected requests leave dmem_addr where the last good access put it
        err_req("mis_lw", 1'b1, 1'b0, 3'd2, 32'h0000_0101, 32'h0000_0108);
        err_req("mis_lh", 1'b1, 1'b0, 3'd5, 32'h0000_0203, 32'h0000_0108);
        err_req("ill_st3", 1'b0, 1'b1, 3'd3, 32'h0000_0100, 32'h0000_0108);
        err_req("ill_ld6", 1'b1, 1'b0, 3'd6, 32'h0000_0100, 32'h0000_0108);
        err_req("ill_both", 1'b1, 1'b1, 3'd2, 32'h0000_0100, 32'h0000_0108);

        // Neither load nor store: ignored
        issue(1'b0, 1'b0, 3'd2, 32'h0000_0400, 32'd0, 5'd1);
        chk("nop_rdy", {31'd0, o_ready}, 32'd1);
        chk("nop_err", {31'd0, o_err}, 32'd0);
        chk("nop_be", {28'd0, o_be}, 32'd0);
        chk("nop_addr", o_addr, 32'h0000_0108);

        // Back-to-back LW accepted in the writeback cycle; busy-time field changes ignored
        @(negedge clk);
        req_is_load = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2;
        req_addr = 32'h0000_0200; req_rd = 5'd3; mem_rdata = 32'hA5A5_0001;
        req_valid = 1'b1;
        @(negedge clk);
        chk("b2b_busy1", {31'd0, o_ready}, 32'd0);
        req_addr = 32'h0000_0204; req_rd = 5'd4;
        @(negedge clk);
        chk("b2b_wbv1", {31'd0, o_wbv}, 32'd1);
        chk("b2b_rd1", {27'd0, o_wbrd}, 32'd3);
        chk("b2b_val1", o_wbval, 32'hA5A5_0001);
        chk("b2b_rdy", {31'd0, o_ready}, 32'd1);
        mem_rdata = 32'h5A5A_0002;
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_gap", {31'd0, o_wbv}, 32'd0);
        chk("b2b_busy2", {31'd0, o_ready}, 32'd0);
        chk("b2b_addr2", o_addr, 32'h0000_0204);
        @(negedge clk);
        chk("b2b_wbv2", {31'd0, o_wbv}, 32'd1);
        chk("b2b_rd2", {27'd0, o_wbrd}, 32'd4);
        chk("b2b_val2", o_wbval, 32'h5A5A_0002);
        @(negedge clk);
        chk("b2b_end", {31'd0, o_wbv}, 32'd0);

        // Reset in the middle of a LOAD
        use3 = 1'b1;
        mem_rdata = 32'h0BAD_0BAD;
        issue(1'b1, 1'b0, 3'd2, 32'h0000_0300, 32'd0, 5'd8);
        chk("rl_busy", {31'd0, o_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rl_rdy", {31'd0, o_ready}, 32'd1);
        chk("rl_be", {28'd0, o_be}, 32'd0);
        chk("rl_addr", o_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_wbv) pulses++;
        end
        chk("rl_nowb", pulses, 32'd0);
        chk("rl_rdy_after", {31'd0, o_ready}, 32'd1);

        // Reset in the middle of a STORE
        use3 = 1'b0;
        mem_rdata = 32'h1234_5678;
        issue(1'b0, 1'b1, 3'd2, 32'h0000_0108, 32'hCAFE_F00D, 5'd0);
        chk("rs_wen", {31'd0, o_wen}, 32'd1);
        chk("rs_bus", o_bus, 32'hCAFE_F00D);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_wen_off", {31'd0, o_wen}, 32'd0);
        chk("rs_bus_rel", o_bus, 32'h1234_5678);
        chk("rs_be", {28'd0, o_be}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rs_rdy_after", {31'd0, o_ready}, 32'd1);
        chk("rs_wbv", {31'd0, o_wbv}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
